core_bus_responder: RTL and testbench
=====================================

# core_bus_responder

Memory-side responder for the rv32e core bus. It sits on the DUT end of the core interface and serves the CPU's load/store requests from an internal word-addressed RAM with a configurable number of wait states. It drives `stall_in` and `data_in` back to the core and bridges the 8-bit extio lines to/from external pins. It is the counterpart of the core's initiator port and is the default memory model in pkt-sim.

## Interface

Port names match the core interface signal names, so the core-side `_in`/`_out` suffixes are seen from the CPU. Clock is `clock`; reset is `reset`, synchronous, active-high.

Parameters:
- `MEMORY_BUS_WIDTH`, 32 — bus width; only 32 is supported.
- `MEM_WORDS`, 1024 — RAM depth in 32-bit words; power of two.
- `WAIT_STATES`, 2 — stall cycles inserted per access; range 0..15.

Ports:
- `clock`  in  1  — system clock.
- `reset`  in  1  — synchronous, active-high.
- `addr_out`  in  32  — byte address from the CPU.
- `data_out`  in  32  — lane-aligned write data.
- `wb_out`  in  4  — byte write enables; bit i writes `data_out[8i+7:8i]`.
- `data_mode_out`  in  3  — bits [1:0] give size (00 none, 01 byte, 10 half, 11 word); bit [2] set means unsigned load.
- `extio_out`  in  8  — CPU extio output.
- `stall_in`  out  1  — stalls the CPU; the CPU holds all request signals stable while it is high.
- `data_in`  out  32  — load result.
- `extio_in`  out  8  — extio value presented to the CPU.
- `ext_pins_in`  in  8  — external pins, asynchronous.
- `ext_pins_out`  out  8  — registered copy of `extio_out`.
- `err_out`  out  1  — sticky access-error flag.

## Operation

- **Request detection:** a request is present when `wb_out != 0` (write) or `data_mode_out[1:0] != 0` (read). A write takes priority when both hold.
- **FSM states:**
  - IDLE: counter = 0.
  - WAIT: counter 1..WAIT_STATES.
- **FSM transitions:**
  - IDLE, request present, WAIT_STATES = 0: complete the access this cycle; stay in IDLE.
  - IDLE, request present, WAIT_STATES > 0: assert `stall_in` combinationally, go to WAIT with counter = 1.
  - WAIT, counter < WAIT_STATES: keep `stall_in` = 1, increment the counter.
  - WAIT, counter = WAIT_STATES: `stall_in` = 0, the access completes, next state is IDLE.
- **Completion cycle:**
  - Write: bytes enabled by `wb_out` are written at the clock edge.
  - Read: `data_in` carries the extracted and extended value. `data_in` is 0 in every non-completion cycle.
- **Read extraction:**
  - Byte = word[8·a+7:8·a], where a = `addr_out[1:0]`.
  - Half = word[16·a1+15:16·a1], where a1 = `addr_out[1]`.
  - Sign-extend unless `data_mode_out[2]` = 1.
- **RAM indexing:** index = `addr_out[log2(MEM_WORDS)+1:2]`. RAM is not cleared by reset.
- **Extio:** `extio_in` = `ext_pins_in` after a 2-flop synchronizer. `ext_pins_out` is `extio_out` registered every cycle.
- **Reset:** forces IDLE, counter = 0. While reset is high: `stall_in` = 0, `data_in` = 0, `extio_in` = 0, `ext_pins_out` = 0, `err_out` = 0, sync flops = 0.
- **Reset mid-access:** a reset during WAIT abandons the access; no write is committed.

## Timing

- **Access latency:** an access presented at cycle t completes at cycle t+WAIT_STATES. `stall_in` is high on cycles t..t+WAIT_STATES-1.
- **Back-to-back:** the request seen in the cycle after completion is a new access. A continuous stream therefore sustains one access per WAIT_STATES+1 cycles.
- **WAIT_STATES = 0:** `stall_in` is never asserted and `data_in` is combinational from address and RAM.
- **Extio latency:** `ext_pins_in` to `extio_in` is 2 cycles; `extio_out` to `ext_pins_out` is 1 cycle.
- **Request withdrawn during WAIT:** protocol violation. The FSM still finishes its count; the write uses the values present on the completion cycle.

## Configuration

- **Macro:** `CORE_BUS_RESPONDER_ERRCHK_EN`.
- **Defined — error checking enabled.** An error is either of:
  - misaligned access: half with `addr_out[0]` = 1, or word with `addr_out[1:0]` ≠ 0;
  - out of range: `addr_out >= 4·MEM_WORDS`.
- **Defined — response to an error:**
  - The access still observes wait states.
  - A write is suppressed and a read returns 0.
  - `err_out` is set on the completion cycle edge and stays 1 until reset.
- **Undefined — no checking:**
  - Upper address bits are ignored, so the address wraps modulo 4·MEM_WORDS.
  - Misaligned halves and words use the aligned-down lane.
  - `err_out` is tied to 0.

## Test plan

- **Wait-state write/read:** WAIT_STATES = 2; word write 0xDEADBEEF to 0x10, then word read 0x10 → `stall_in` high exactly 2 cycles per access; `data_in` = 0xDEADBEEF on the completion cycle and 0 otherwise.
- **Byte write and sign extension:** byte write `wb_out` = 0100, `data_out` = 0x00800000 at 0x20, onto a word preloaded with 0x11223344 → word becomes 0x11803344. Signed byte read at 0x22 → 0xFFFFFF80; unsigned byte read → 0x00000080.
- **Zero wait states:** WAIT_STATES = 0; 4 back-to-back word reads → `stall_in` never high; one result per cycle.
- **Reset mid-access:** assert reset during WAIT of a write to 0x30 (old value 0x0) → FSM in IDLE; read of 0x30 returns 0x0; all outputs 0 during reset.
- **Error checking:** with ERRCHK_EN, word read at 0x6 and word write at 4·MEM_WORDS → read returns 0, the write does not alias to address 0, `err_out` = 1 and stays set until reset. Without the macro, the write lands at word 0.
- **Extio:** `ext_pins_in` = 0xA5 → `extio_in` = 0xA5 two cycles later; `extio_out` = 0x3C → `ext_pins_out` = 0x3C one cycle later.

Source files
------------

// File: rtl/core_bus_responder.sv
// Core-bus memory responder: word RAM with WAIT_STATES stall cycles per access, plus extio pin bridging.
// Optional access-error checking is compiled in with `define CORE_BUS_RESPONDER_ERRCHK_EN.
module core_bus_responder #(
  parameter int MEMORY_BUS_WIDTH = 32,
  parameter int MEM_WORDS        = 1024,
  parameter int WAIT_STATES      = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [MEMORY_BUS_WIDTH-1:0] addr_out,
  input  logic [MEMORY_BUS_WIDTH-1:0] data_out,
  input  logic [3:0]                  wb_out,
  input  logic [2:0]                  data_mode_out,
  input  logic [7:0]                  extio_out,
  output logic                        stall_in,
  output logic [MEMORY_BUS_WIDTH-1:0] data_in,
  output logic [7:0]                  extio_in,
  input  logic [7:0]                  ext_pins_in,
  output logic [7:0]                  ext_pins_out,
  output logic                        err_out
);

  localparam int          AW         = $clog2(MEM_WORDS);
  localparam logic [3:0]  WS         = 4'(WAIT_STATES);
  localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) << 2;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_err;
  logic [7:0]  r_sync1;
  logic [7:0]  r_sync2;
  logic [7:0]  r_pins_out;
  logic [31:0] r_mem [MEM_WORDS];

  logic          w_wr;
  logic          w_rd;
  logic          w_req;
  logic          w_done;
  logic          w_err;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_word;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_ext;
  logic          w_unused;

  assign w_wr     = |wb_out;
  assign w_rd     = |data_mode_out[1:0];
  assign w_req    = w_wr | w_rd;
  assign w_idx    = addr_out[AW+1:2];
  assign w_word   = r_mem[w_idx];
  assign w_unused = &{1'b0, addr_out[31:AW+2]};

  // Completion is the cycle the access takes effect; stall covers every earlier cycle.
  assign w_done   = !reset && (((r_state == S_IDLE) && w_req && (WS == 4'd0)) ||
                               ((r_state == S_WAIT) && (r_cnt == WS)));
  assign stall_in = !reset && (((r_state == S_IDLE) && w_req && (WS != 4'd0)) ||
                               ((r_state == S_WAIT) && (r_cnt < WS)));

  always_comb begin
    w_err = 1'b0;
`ifdef CORE_BUS_RESPONDER_ERRCHK_EN
    if (((data_mode_out[1:0] == 2'b10) && addr_out[0]) ||
        ((data_mode_out[1:0] == 2'b11) && (addr_out[1:0] != 2'b00)) ||
        ({1'b0, addr_out} >= ADDR_LIMIT)) begin
      w_err = 1'b1;
    end else begin
      w_err = 1'b0;
    end
`else
    w_err = 1'b0;
`endif
  end

  always_comb begin
    w_byte = w_word[{addr_out[1:0], 3'b000} +: 8];
    w_half = w_word[{addr_out[1], 4'b0000} +: 16];
    case (data_mode_out[1:0])
      2'b01:   w_ext = {{24{w_byte[7] & ~data_mode_out[2]}}, w_byte};
      2'b10:   w_ext = {{16{w_half[15] & ~data_mode_out[2]}}, w_half};
      2'b11:   w_ext = w_word;
      default: w_ext = 32'd0;
    endcase
    if (w_done && w_rd && !w_wr && !w_err) begin
      data_in = w_ext;
    end else begin
      data_in = 32'd0;
    end
  end

  // RAM has no reset; w_done is already false while reset is high, so an abandoned write never lands.
  always_ff @(posedge clock) begin
    if (w_done && w_wr && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (wb_out[i]) begin
          r_mem[w_idx][8*i +: 8] <= data_out[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_err      <= 1'b0;
      r_sync1    <= 8'd0;
      r_sync2    <= 8'd0;
      r_pins_out <= 8'd0;
    end else begin
      r_sync1    <= ext_pins_in;
      r_sync2    <= r_sync1;
      r_pins_out <= extio_out;
      if (w_done && w_err) begin
        r_err <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_req && (WS != 4'd0)) begin
            r_state <= S_WAIT;
            r_cnt   <= 4'd1;
          end
        end
        S_WAIT: begin
          // The count runs to completion even if the CPU withdraws the request.
          if (r_cnt < WS) begin
            r_cnt <= r_cnt + 4'd1;
          end else begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end

  assign extio_in     = r_sync2;
  assign ext_pins_out = r_pins_out;
  assign err_out      = r_err;

endmodule

// File: tb/tb_core_bus_responder.sv
// Self-checking bench for core_bus_responder: one instance with 2 wait states, one with none.
module tb_core_bus_responder;

  localparam int WS = 2;
  localparam int MW = 1024;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [31:0] addr = 32'd0, wdata = 32'd0, rdata;
  logic [3:0]  wb = 4'd0;
  logic [2:0]  mode = 3'd0;
  logic [7:0]  xo = 8'd0, pins_in = 8'd0, xi, pins_out;
  logic        stall, err;

  logic [31:0] a0 = 32'd0, d0 = 32'd0, rd0;
  logic [3:0]  wb0 = 4'd0;
  logic [2:0]  m0 = 3'd0;
  logic [7:0]  xo0 = 8'd0, pi0 = 8'd0, xi0, po0;
  logic        st0, er0;

  core_bus_responder #(.MEMORY_BUS_WIDTH(32), .MEM_WORDS(MW), .WAIT_STATES(WS)) dut (
    .clock(clock), .reset(reset), .addr_out(addr), .data_out(wdata), .wb_out(wb),
    .data_mode_out(mode), .extio_out(xo), .stall_in(stall), .data_in(rdata),
    .extio_in(xi), .ext_pins_in(pins_in), .ext_pins_out(pins_out), .err_out(err));

  core_bus_responder #(.MEMORY_BUS_WIDTH(32), .MEM_WORDS(MW), .WAIT_STATES(0)) dut0 (
    .clock(clock), .reset(reset), .addr_out(a0), .data_out(d0), .wb_out(wb0),
    .data_mode_out(m0), .extio_out(xo0), .stall_in(st0), .data_in(rd0),
    .extio_in(xi0), .ext_pins_in(pi0), .ext_pins_out(po0), .err_out(er0));

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] model  [16];
  logic [31:0] model0 [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_read(input logic [31:0] word, input logic [31:0] a,
                                           input logic [2:0] m);
    logic [31:0] v;
    int sh;
    v = 32'd0;
    if (m[1:0] == 2'd1) begin
      sh = int'(a % 4) * 8;
      v = (word >> sh) & 32'hFF;
      if (!m[2] && v >= 32'h80) v = v + 32'hFFFFFF00;
    end else if (m[1:0] == 2'd2) begin
      sh = int'((a / 2) % 2) * 16;
      v = (word >> sh) & 32'hFFFF;
      if (!m[2] && v >= 32'h8000) v = v + 32'hFFFF0000;
    end else if (m[1:0] == 2'd3) begin
      v = word;
    end
    return v;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] w);
    logic [31:0] r, msk;
    r = old;
    for (int i = 0; i < 4; i++) begin
      msk = 32'hFF << (8 * i);
      if (w[i]) r = (r & ~msk) | (d & msk);
    end
    return r;
  endfunction

  // One access on the WS=2 instance: stall for WS cycles, result only on the completion cycle.
  task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] w, input logic [2:0] m, input logic [31:0] exp,
                        input string tag);
    addr = a; wdata = d; wb = wr ? w : 4'd0; mode = m;
    for (int c = 0; c <= WS; c++) begin
      #2;
      check({tag, "_stall"}, {31'd0, stall}, (c < WS) ? 32'd1 : 32'd0);
      check({tag, "_data"}, rdata, (c == WS && !wr) ? exp : 32'd0);
      @(posedge clock); #1;
    end
    wb = 4'd0; mode = 3'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v, a;
    logic [3:0]  w;
    logic [2:0]  m;
    int idx;

    // reset with a request pending
    addr = 32'd0; mode = 3'b011; a0 = 32'd0; m0 = 3'b011;
    @(posedge clock); @(posedge clock); #1;
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_data", rdata, 32'd0);
    check("rst_xi", {24'd0, xi}, 32'd0);
    check("rst_pins_out", {24'd0, pins_out}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst0_stall", {31'd0, st0}, 32'd0);
    check("rst0_data", rd0, 32'd0);
    mode = 3'd0; m0 = 3'd0;
    reset = 1'b0;
    @(posedge clock); #1;

    // extio
    pins_in = 8'hA5; xo = 8'h3C;
    @(posedge clock); #1;
    check("xo_1cyc", {24'd0, pins_out}, 32'h3C);
    check("xi_1cyc", {24'd0, xi}, 32'h00);
    @(posedge clock); #1;
    check("xi_2cyc", {24'd0, xi}, 32'hA5);

    // preload
    for (int i = 0; i < 16; i++) begin
      model[i] = $urandom;
      access(1'b1, 32'(i * 4), model[i], 4'hF, 3'b011, 32'd0, "pre");
    end

    // directed wait-state write/read
    access(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b011, 32'd0, "ws_wr");
    model[4] = 32'hDEADBEEF;
    access(1'b0, 32'h10, 32'd0, 4'd0, 3'b011, 32'hDEADBEEF, "ws_rd");

    // byte write and sign extension
    access(1'b1, 32'h20, 32'h11223344, 4'hF, 3'b011, 32'd0, "bw_pre");
    access(1'b1, 32'h20, 32'h00800000, 4'b0100, 3'b001, 32'd0, "bw_wr");
    model[8] = 32'h11803344;
    access(1'b0, 32'h20, 32'd0, 4'd0, 3'b011, 32'h11803344, "bw_word");
    access(1'b0, 32'h22, 32'd0, 4'd0, 3'b001, 32'hFFFFFF80, "bw_signed");
    access(1'b0, 32'h22, 32'd0, 4'd0, 3'b101, 32'h00000080, "bw_unsigned");

    // random traffic against the model
    for (int n = 0; n < 30; n++) begin
      idx = $urandom_range(0, 15);
      if ($urandom_range(0, 2) == 0) begin
        w = 4'($urandom_range(1, 15));
        v = $urandom;
        access(1'b1, 32'(idx * 4), v, w, 3'b011, 32'd0, "rnd_wr");
        model[idx] = merge(model[idx], v, w);
      end else begin
        m = {1'($urandom_range(0, 1)), 2'($urandom_range(1, 3))};
        a = 32'(idx * 4);
        if (m[1:0] == 2'd1) a = a + 32'($urandom_range(0, 3));
        else if (m[1:0] == 2'd2) a = a + 32'(2 * $urandom_range(0, 1));
        access(1'b0, a, 32'd0, 4'd0, m, ref_read(model[idx], a, m), "rnd_rd");
      end
    end

    // reset mid-access
    access(1'b1, 32'h30, 32'h0, 4'hF, 3'b011, 32'd0, "mid_pre");
    model[12] = 32'h0;
    pins_in = 8'hFF; xo = 8'hFF;
    @(posedge clock); @(posedge clock); #1;
    addr = 32'h30; wdata = 32'hFFFFFFFF; wb = 4'hF; mode = 3'b011;
    #2;
    check("mid_stall0", {31'd0, stall}, 32'd1);
    @(posedge clock); #1;
    reset = 1'b1;
    #2;
    check("mid_rst_stall", {31'd0, stall}, 32'd0);
    check("mid_rst_data", rdata, 32'd0);
    @(posedge clock); #1;
    check("mid_rst_xi", {24'd0, xi}, 32'd0);
    check("mid_rst_pins", {24'd0, pins_out}, 32'd0);
    check("mid_rst_err", {31'd0, err}, 32'd0);
    @(posedge clock); #1;
    wb = 4'd0; mode = 3'd0; reset = 1'b0;
    @(posedge clock); #1;
    access(1'b0, 32'h30, 32'd0, 4'd0, 3'b011, 32'h0, "mid_rd");

    // error handling
    check("err_before", {31'd0, err}, 32'd0);
`ifdef CORE_BUS_RESPONDER_ERRCHK_EN
    access(1'b0, 32'h6, 32'd0, 4'd0, 3'b011, 32'd0, "err_misal");
    check("err_set", {31'd0, err}, 32'd1);
    access(1'b1, 32'(4 * MW), 32'h12345678, 4'hF, 3'b011, 32'd0, "err_oor_wr");
    access(1'b0, 32'h0, 32'd0, 4'd0, 3'b011, model[0], "err_noalias");
    check("err_sticky", {31'd0, err}, 32'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("err_cleared", {31'd0, err}, 32'd0);
`else
    access(1'b0, 32'h6, 32'd0, 4'd0, 3'b011, model[1], "nochk_misal");
    access(1'b1, 32'(4 * MW), 32'h12345678, 4'hF, 3'b011, 32'd0, "nochk_wr");
    model[0] = 32'h12345678;
    access(1'b0, 32'h0, 32'd0, 4'd0, 3'b011, model[0], "nochk_alias");
    check("nochk_err", {31'd0, err}, 32'd0);
`endif

    // zero wait states: single-cycle writes then back-to-back reads
    @(posedge clock); #1;
    for (int i = 0; i < 4; i++) begin
      model0[i] = $urandom;
      a0 = 32'(i * 4); d0 = model0[i]; wb0 = 4'hF; m0 = 3'b011;
      #2;
      check("z_wr_stall", {31'd0, st0}, 32'd0);
      @(posedge clock); #1;
    end
    wb0 = 4'd0;
    for (int i = 3; i >= 0; i--) begin
      a0 = 32'(i * 4); m0 = 3'b011;
      #2;
      check("z_rd_stall", {31'd0, st0}, 32'd0);
      check("z_rd_data", rd0, model0[i]);
      @(posedge clock); #1;
    end
    m0 = 3'd0;
    #2;
    check("z_idle_data", rd0, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
